serdesphy_ana_ce_sched: RTL

Clock-enable scheduler for the analog common block: one programmable tick divider shared among NREQ analog sub-block requesters (calibration, bias settle, PLL lock timers). Each requester asks for a burst of N tick pulses; the scheduler grants one requester at a time and emits single-cycle enables every PERIOD+1 clocks to that requester only. It sits between the register file (period and burst lengths) and the analog control FSMs.

---
 rtl/serdesphy_ana_ce_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/serdesphy_ana_ce_sched.sv
// Clock-enable scheduler: one shared tick divider granted to one analog requester at a time for a burst of ticks.
// Define SERDESPHY_CE_SCHED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module serdesphy_ana_ce_sched #(
   parameter int NREQ    = 4,
   parameter int CNT_W   = 10,
   parameter int BURST_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [CNT_W-1:0]         period,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*BURST_W-1:0]  burst_len,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          ce_vec,
   output logic [NREQ-1:0]          done,
   output logic                     busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW1   = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nx;
   logic [CNT_W-1:0]   per_q;
   logic [CNT_W-1:0]   per_nx;
   logic [BURST_W-1:0] rem;
   logic [BURST_W-1:0] rem_nx;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   owner_nx;
   logic [PTR_W-1:0]   owner_inc;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_nx;
   logic [NREQ-1:0]    grant_nx;
   logic [NREQ-1:0]    ce_nx;
   logic [NREQ-1:0]    done_nx;
   logic               busy_nx;
   logic               win_vld;
   logic [PTR_W-1:0]   win_idx;
   logic [BURST_W-1:0] win_len;
`ifndef SERDESPHY_CE_SCHED_PRIO_EN
   logic [PW1-1:0]     rr_sum;
`endif

   // Winner selection; only consulted while idle.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
`ifdef SERDESPHY_CE_SCHED_PRIO_EN
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_vld = 1'b1;
            win_idx = PTR_W'(i);
         end
      end
`else
      rr_sum = '0;
      for (int i = 0; i < NREQ; i++) begin
         rr_sum = {1'b0, ptr} + PW1'(i);
         if (rr_sum >= PW1'(NREQ)) begin
            rr_sum = rr_sum - PW1'(NREQ);
         end
         if (!win_vld && req[rr_sum[PTR_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = rr_sum[PTR_W-1:0];
         end
      end
`endif
   end

   assign win_len   = burst_len[int'(win_idx)*BURST_W +: BURST_W];
   assign owner_inc = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;

   // Next-state and registered-output logic; abort outranks a same-cycle final tick.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      per_nx   = per_q;
      rem_nx   = rem;
      owner_nx = owner;
      ptr_nx   = ptr;
      grant_nx = grant;
      ce_nx    = '0;
      done_nx  = '0;
      unique case (state)
         ST_IDLE: begin
            if (enable && win_vld) begin
               grant_nx          = '0;
               grant_nx[win_idx] = 1'b1;
               owner_nx          = win_idx;
               per_nx            = period;
               rem_nx            = (win_len == '0) ? BURST_W'(1) : win_len;
               cnt_nx            = '0;
               state_nx          = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable || !req[owner]) begin
               grant_nx = '0;
               cnt_nx   = '0;
               rem_nx   = '0;
               ptr_nx   = owner_inc;
               state_nx = ST_IDLE;
            end else if (cnt == per_q) begin
               cnt_nx       = '0;
               ce_nx[owner] = 1'b1;
               rem_nx       = rem - 1'b1;
               if (rem == BURST_W'(1)) begin
                  state_nx = ST_DONE;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         ST_DONE: begin
            grant_nx       = '0;
            done_nx[owner] = 1'b1;
            ptr_nx         = owner_inc;
            state_nx       = ST_IDLE;
         end
         default: begin
            grant_nx = '0;
            state_nx = ST_IDLE;
         end
      endcase
`ifdef SERDESPHY_CE_SCHED_PRIO_EN
      ptr_nx = '0;
`endif
      busy_nx = (state_nx != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         per_q  <= '0;
         rem    <= '0;
         owner  <= '0;
         ptr    <= '0;
         grant  <= '0;
         ce_vec <= '0;
         done   <= '0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         per_q  <= per_nx;
         rem    <= rem_nx;
         owner  <= owner_nx;
         ptr    <= ptr_nx;
         grant  <= grant_nx;
         ce_vec <= ce_nx;
         done   <= done_nx;
         busy   <= busy_nx;
      end
   end

endmodule
